// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, latch-control bundle, r0 index.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MD_WAIT = 2'd1,
        ST_MD_DONE = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_en;
        logic fd_en;
        logic dx_en;
        logic xm_en;
        logic mw_en;
        logic fd_flush;
        logic dx_flush;
        logic xm_bubble;
        logic md_start;
        logic md_busy;
    } ctrl_t;

    // Free-running pipeline: every latch advances, nothing flushed.
    localparam ctrl_t CTRL_RUN = 10'b11111_00000;

endpackage

// File: rtl/md_wait_timer.sv
// Mult/div watchdog counter: cleared on start, counts MD_WAIT cycles, flags the last allowed one.
module md_wait_timer #(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic clr_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_term
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc)
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign o_term = (r_cnt == CNT_W'(MD_TIMEOUT - 1));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: latch enables/flushes for load-use, mult/div and taken-branch cases.
// Owns the mult/div start handshake and a watchdog that forces completion with an exception.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       x_is_load,
    input  logic       x_is_md,
    input  logic [4:0] x_rd,
    input  logic [4:0] d_rs1,
    input  logic [4:0] d_rs2,
    input  logic       d_use_rs1,
    input  logic       d_use_rs2,
    input  logic       x_br_taken,
    input  logic       md_ready,
    input  logic       md_exc,
    output logic       pc_en,
    output logic       fd_en,
    output logic       dx_en,
    output logic       xm_en,
    output logic       mw_en,
    output logic       fd_flush,
    output logic       dx_flush,
    output logic       xm_bubble,
    output logic       md_start,
    output logic       md_busy,
    output logic       md_exc_out
);

    state_e r_state, w_nstate;
    logic   r_md_exc, w_md_exc_nxt;
    logic   w_load_use, w_tmr_clr, w_tmr_inc, w_tmr_term;
    ctrl_t  w_ctrl, w_ctrl_g;

    md_wait_timer #(
        .MD_TIMEOUT (MD_TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_timer (
        .clk    (clk),
        .clr_n  (clr_n),
        .i_clr  (w_tmr_clr),
        .i_inc  (w_tmr_inc),
        .o_term (w_tmr_term)
    );

    assign w_load_use = x_is_load && (x_rd != REG_ZERO) &&
                        ((d_use_rs1 && (d_rs1 == x_rd)) || (d_use_rs2 && (d_rs2 == x_rd)));

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state  <= ST_RUN;
            r_md_exc <= 1'b0;
        end else begin
            r_state  <= w_nstate;
            r_md_exc <= w_md_exc_nxt;
        end
    end

    // Priority in RUN: taken branch, then mult/div start, then load-use.
    always_comb begin
        w_nstate     = r_state;
        w_ctrl       = CTRL_RUN;
        w_md_exc_nxt = 1'b0;
        w_tmr_clr    = 1'b0;
        w_tmr_inc    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (x_br_taken) begin
                    w_ctrl.fd_flush = 1'b1;
                    w_ctrl.dx_flush = 1'b1;
                end else if (x_is_md) begin
                    w_ctrl.pc_en     = 1'b0;
                    w_ctrl.fd_en     = 1'b0;
                    w_ctrl.dx_en     = 1'b0;
                    w_ctrl.xm_bubble = 1'b1;
                    w_ctrl.md_start  = 1'b1;
                    w_tmr_clr        = 1'b1;
                    w_nstate         = ST_MD_WAIT;
                end else if (w_load_use) begin
                    w_ctrl.pc_en    = 1'b0;
                    w_ctrl.fd_en    = 1'b0;
                    w_ctrl.dx_flush = 1'b1;
                end
            end
            ST_MD_WAIT: begin
                w_ctrl.pc_en     = 1'b0;
                w_ctrl.fd_en     = 1'b0;
                w_ctrl.dx_en     = 1'b0;
                w_ctrl.xm_bubble = 1'b1;
                w_ctrl.md_busy   = 1'b1;
                w_tmr_inc        = 1'b1;
                if (md_ready) begin
                    w_nstate     = ST_MD_DONE;
                    w_md_exc_nxt = md_exc;
                end else if (w_tmr_term) begin
                    w_nstate     = ST_MD_DONE;
                    w_md_exc_nxt = 1'b1;
                end
            end
            ST_MD_DONE: w_nstate = ST_RUN;
            default:    w_nstate = ST_RUN;
        endcase
    end

    // Held reset silences every Mealy output, not just the registered ones.
    assign w_ctrl_g   = clr_n ? w_ctrl : '0;
    assign pc_en      = w_ctrl_g.pc_en;
    assign fd_en      = w_ctrl_g.fd_en;
    assign dx_en      = w_ctrl_g.dx_en;
    assign xm_en      = w_ctrl_g.xm_en;
    assign mw_en      = w_ctrl_g.mw_en;
    assign fd_flush   = w_ctrl_g.fd_flush;
    assign dx_flush   = w_ctrl_g.dx_flush;
    assign xm_bubble  = w_ctrl_g.xm_bubble;
    assign md_start   = w_ctrl_g.md_start;
    assign md_busy    = w_ctrl_g.md_busy;
    assign md_exc_out = r_md_exc;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations plus a random run
// compared every cycle against a behavioural model of the stall/flush rules.
module tb_pipe_hazard_ctrl;

    localparam int MD_TIMEOUT = 40;
    localparam int CNT_W      = 8;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       x_is_load = 1'b0, x_is_md = 1'b0, x_br_taken = 1'b0;
    logic       d_use_rs1 = 1'b0, d_use_rs2 = 1'b0, md_ready = 1'b0, md_exc = 1'b0;
    logic [4:0] x_rd = 5'd0, d_rs1 = 5'd0, d_rs2 = 5'd0;
    logic       pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush;
    logic       xm_bubble, md_start, md_busy, md_exc_out;
    logic [10:0] dut_v;

    int n_chk  = 0;
    int n_fail = 0;

    // model: in_md = waiting on mult/div, waited = wait cycles elapsed, done = result cycle
    bit m_in_md = 1'b0, m_done = 1'b0, m_exc = 1'b0;
    int m_waited = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .clr_n(clr_n), .x_is_load(x_is_load), .x_is_md(x_is_md), .x_rd(x_rd),
        .d_rs1(d_rs1), .d_rs2(d_rs2), .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2),
        .x_br_taken(x_br_taken), .md_ready(md_ready), .md_exc(md_exc),
        .pc_en(pc_en), .fd_en(fd_en), .dx_en(dx_en), .xm_en(xm_en), .mw_en(mw_en),
        .fd_flush(fd_flush), .dx_flush(dx_flush), .xm_bubble(xm_bubble),
        .md_start(md_start), .md_busy(md_busy), .md_exc_out(md_exc_out)
    );

    assign dut_v = {pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush,
                    xm_bubble, md_start, md_busy, md_exc_out};

    task automatic chk1(string nm, logic act, logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chkv(string nm, logic [10:0] act, logic [10:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chki(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit hazard();
        if (!x_is_load || x_rd == 5'd0) return 1'b0;
        return (d_use_rs1 && d_rs1 == x_rd) || (d_use_rs2 && d_rs2 == x_rd);
    endfunction

    // Order: pc fd dx xm mw fd_flush dx_flush bubble start busy exc
    function automatic logic [10:0] model_out();
        bit [4:0] en = 5'b11111;
        bit ff = 0, df = 0, bub = 0, st = 0, busy = 0, ex = 0;
        if (!clr_n) return 11'd0;
        if (m_done) begin
            ex = m_exc;
        end else if (m_in_md) begin
            en = 5'b00011; bub = 1; busy = 1;
        end else if (x_br_taken) begin
            ff = 1; df = 1;
        end else if (x_is_md) begin
            en = 5'b00011; bub = 1; st = 1;
        end else if (hazard()) begin
            en = 5'b00111; df = 1;
        end
        return {en, ff, df, bub, st, busy, ex};
    endfunction

    task automatic model_step();
        if (!clr_n) begin
            m_in_md = 0; m_done = 0; m_exc = 0; m_waited = 0;
        end else if (m_done) begin
            m_done = 0; m_exc = 0;
        end else if (m_in_md) begin
            m_waited++;
            if (md_ready) begin
                m_in_md = 0; m_done = 1; m_exc = md_exc;
            end else if (m_waited == MD_TIMEOUT) begin
                m_in_md = 0; m_done = 1; m_exc = 1;
            end
        end else if (!x_br_taken && x_is_md) begin
            m_in_md = 1; m_waited = 0;
        end
    endtask

    // Compare at the falling edge, advance model, return just after the next rising edge.
    task automatic cycle();
        @(negedge clk);
        chkv("model", dut_v, model_out());
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        x_is_load = 0; x_is_md = 0; x_br_taken = 0; md_ready = 0; md_exc = 0;
        d_use_rs1 = 0; d_use_rs2 = 0; x_rd = 5'd0; d_rs1 = 5'd0; d_rs2 = 5'd0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        idle();
        #2 chkv("reset outputs", dut_v, 11'd0);
        cycle(); cycle();
        clr_n = 1'b1;
        #1 chkv("after reset idle", dut_v, 11'b11111_000000);
        cycle();

        // load-use on rs1, then clear, then r0 destination
        x_is_load = 1; x_rd = 5'd5; d_rs1 = 5'd5; d_use_rs1 = 1;
        #1 chkv("load-use stall", dut_v, 11'b00111_010000);
        cycle();
        idle();
        #1 chkv("load-use released", dut_v, 11'b11111_000000);
        cycle();
        x_is_load = 1; x_rd = 5'd0; d_rs1 = 5'd0; d_use_rs1 = 1;
        #1 chk1("r0 no stall pc_en", pc_en, 1'b1);
        chk1("r0 no dx_flush", dx_flush, 1'b0);
        cycle();

        // branch wins over load-use, and over mult/div start
        x_is_load = 1; x_rd = 5'd9; d_rs2 = 5'd9; d_use_rs2 = 1; x_br_taken = 1;
        #1 chkv("branch over load-use", dut_v, 11'b11111_110000);
        cycle();
        idle(); x_is_md = 1; x_br_taken = 1;
        #1 chk1("branch over md_start", md_start, 1'b0);
        cycle();

        // mult/div: ready on 8th busy cycle, x_is_md still high in MD_DONE
        idle(); x_is_md = 1;
        #1 chkv("md start", dut_v, 11'b00011_001100);
        cycle();
        x_is_md = 0; cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            md_ready = (i == 8);
            if (md_busy) cnt++;
            cycle();
        end
        chki("md busy cycles", cnt, 8);
        md_ready = 0; x_is_md = 1;
        #1 chkv("md done", dut_v, 11'b11111_000000);
        cycle();

        // still x_is_md in RUN: new start which then times out
        #1 chk1("md restart", md_start, 1'b1);
        cycle();
        x_is_md = 0; cnt = 0;
        while (md_busy && cnt < 100) begin
            cnt++;
            cycle();
        end
        chki("timeout busy cycles", cnt, MD_TIMEOUT);
        chkv("timeout done", dut_v, 11'b11111_000001);
        cycle();
        chk1("exc cleared", md_exc_out, 1'b0);

        // reset during MD_WAIT cycle 3
        x_is_md = 1;
        cycle();
        x_is_md = 0;
        cycle(); cycle();
        chk1("wait cycle 3 busy", md_busy, 1'b1);
        x_is_load = 1; x_br_taken = 1;
        clr_n = 1'b0;
        #1 chkv("reset mid-op", dut_v, 11'd0);
        cycle(); cycle();
        idle(); clr_n = 1'b1;
        #1 chkv("run after reset", dut_v, 11'b11111_000000);
        cycle();

        // exception pass-through, then stray md_ready in RUN
        x_is_md = 1;
        cycle();
        x_is_md = 0;
        cycle(); cycle();
        md_ready = 1; md_exc = 1;
        cycle();
        md_ready = 0; md_exc = 0;
        #1 chk1("exc in done", md_exc_out, 1'b1);
        cycle();
        chk1("exc after done", md_exc_out, 1'b0);
        md_ready = 1; md_exc = 1;
        cycle();
        idle();
        #1 chkv("stray ready ignored", dut_v, 11'b11111_000000);
        cycle();

        // randomized run checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = int'($urandom_range(15));
            x_is_md    = (r == 0);
            x_is_load  = (r >= 1 && r <= 6);
            x_br_taken = ($urandom_range(7) == 0);
            x_rd       = 5'($urandom_range(3));
            d_rs1      = 5'($urandom_range(3));
            d_rs2      = 5'($urandom_range(3));
            d_use_rs1  = 1'($urandom_range(1));
            d_use_rs2  = 1'($urandom_range(1));
            md_ready   = ($urandom_range(11) == 0);
            md_exc     = 1'($urandom_range(1));
            if (!clr_n) clr_n = 1'b1;
            else if ($urandom_range(299) == 0) clr_n = 1'b0;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
